// File: rtl/encapsulation_mb.sv
// encapsulation_mb: transmit-buffer arbiter and frame-header encapsulator.
// Pending buffers compete on a 32-bit arbitration key. The winner is latched
// and presented to the LLC as a 39-bit header plus a real data length. It is
// held until the LLC reports success or error, or drops activ.
module encapsulation_mb #(
  parameter int NBUF = 4,
  parameter int SW   = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NBUF-1:0]      txreq,
  input  logic [NBUF-1:0]      abort,
  input  logic [29*NBUF-1:0]   identifier,
  input  logic [NBUF-1:0]      extended,
  input  logic [NBUF-1:0]      remote,
  input  logic [4*NBUF-1:0]    datalen,
  input  logic                 activ,
  input  logic                 txok,
  input  logic                 txerr,
  output logic [38:0]          message,
  output logic [3:0]           tmlen,
  output logic [SW-1:0]        selbuf,
  output logic                 valid,
  output logic [NBUF-1:0]      pending,
  output logic [NBUF-1:0]      txdone
);

  typedef enum logic [1:0] {IDLE = 2'd0, SELECT = 2'd1, LOCK = 2'd2} state_t;

  // Arbitration key: lower value wins on the bus. A standard frame beats an
  // extended frame with the same base ID because the IDE position is 0.
  function automatic logic [31:0] arb_key(input logic [28:0] id,
                                          input logic        ext,
                                          input logic        rtr);
    if (ext) return {id[28:18], 2'b11, id[17:0], rtr};
    else     return {id[28:18], rtr, 1'b0, 18'd0, 1'b0};
  endfunction

  // Real payload length: remote frames carry no data; DLC above 8 means 8.
  function automatic logic [3:0] sat_len(input logic [3:0] dlc,
                                         input logic       rtr);
    if (rtr)            return 4'd0;
    else if (dlc > 4'd8) return 4'd8;
    else                return dlc;
  endfunction

  // Header layout for the shifter/CRC: raw DLC is kept in the low nibble.
  function automatic logic [38:0] build_header(input logic [28:0] id,
                                               input logic        ext,
                                               input logic        rtr,
                                               input logic [3:0]  dlc);
    if (ext) return {1'b0, id[28:18], 2'b11, id[17:0], rtr, 2'b00, dlc};
    else     return {1'b0, 20'd0, id[28:18], rtr, 2'b00, dlc};
  endfunction

  state_t            state_q, state_d;
  logic              activ_prev_q, activ_prev_d;
  logic [SW-1:0]     win_q, win_d;
  logic [38:0]       message_q, message_d;
  logic [3:0]        tmlen_q, tmlen_d;
  logic [SW-1:0]     selbuf_q, selbuf_d;
  logic              valid_q, valid_d;
  logic [NBUF-1:0]   pending_q, pending_d;
  logic [NBUF-1:0]   txdone_q, txdone_d;

  logic [SW-1:0]     arb_idx;
  logic [31:0]       best_key;
  logic [31:0]       cand_key;
  logic              found;
  logic [28:0]       sel_id;
  logic              sel_ext;
  logic              sel_rtr;
  logic [3:0]        sel_dlc;
  logic [NBUF-1:0]   lock_oh;
  logic [NBUF-1:0]   clr;

  // Pick the pending buffer with the lowest key; strict compare keeps the lowest index on ties.
  always_comb begin
    arb_idx  = '0;
    best_key = '1;
    cand_key = '0;
    found    = 1'b0;
    for (int i = 0; i < NBUF; i++) begin
      cand_key = arb_key(identifier[29*i +: 29], extended[i], remote[i]);
      if (pending_q[i] && (!found || cand_key < best_key)) begin
        found    = 1'b1;
        best_key = cand_key;
        arb_idx  = SW'(i);
      end
    end
  end

  // Route the registered winner's descriptor and build the locked-buffer one-hot mask.
  always_comb begin
    sel_id  = '0;
    sel_ext = 1'b0;
    sel_rtr = 1'b0;
    sel_dlc = '0;
    lock_oh = '0;
    for (int i = 0; i < NBUF; i++) begin
      if (SW'(i) == win_q) begin
        sel_id  = identifier[29*i +: 29];
        sel_ext = extended[i];
        sel_rtr = remote[i];
        sel_dlc = datalen[4*i +: 4];
      end
      lock_oh[i] = (SW'(i) == selbuf_q);
    end
  end

  // Next-state, output-register and pending-flag computation.
  always_comb begin
    state_d      = state_q;
    activ_prev_d = activ;
    win_d        = win_q;
    message_d    = message_q;
    tmlen_d      = tmlen_q;
    selbuf_d     = selbuf_q;
    valid_d      = valid_q;
    txdone_d     = '0;
    clr          = abort;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (activ && !activ_prev_q && (|pending_q)) begin
          state_d = SELECT;
          win_d   = arb_idx;
        end
      end
      SELECT: begin
        state_d   = LOCK;
        selbuf_d  = win_q;
        message_d = build_header(sel_id, sel_ext, sel_rtr, sel_dlc);
        tmlen_d   = sat_len(sel_dlc, sel_rtr);
        valid_d   = 1'b1;
      end
      LOCK: begin
        // The locked buffer cannot be aborted out from under the LLC.
        clr = abort & ~lock_oh;
        if (txok) begin
          txdone_d = lock_oh;
          clr      = clr | lock_oh;
          state_d  = IDLE;
          valid_d  = 1'b0;
        end else if (txerr || !activ) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    // New requests take priority over any clear in the same cycle.
    pending_d = (pending_q & ~clr) | txreq;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      activ_prev_q <= 1'b0;
      win_q        <= '0;
      message_q    <= '0;
      tmlen_q      <= '0;
      selbuf_q     <= '0;
      valid_q      <= 1'b0;
      pending_q    <= '0;
      txdone_q     <= '0;
    end else begin
      state_q      <= state_d;
      activ_prev_q <= activ_prev_d;
      win_q        <= win_d;
      message_q    <= message_d;
      tmlen_q      <= tmlen_d;
      selbuf_q     <= selbuf_d;
      valid_q      <= valid_d;
      pending_q    <= pending_d;
      txdone_q     <= txdone_d;
    end
  end

  assign message = message_q;
  assign tmlen   = tmlen_q;
  assign selbuf  = selbuf_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign txdone  = txdone_q;

endmodule

// File: tb/tb_encapsulation_mb.sv
// Directed bench for encapsulation_mb with hand-computed expected values.
module tb_encapsulation_mb;

  localparam int NBUF = 4;
  localparam int SW   = 3;

  logic                clock;
  logic                reset;
  logic [NBUF-1:0]     txreq;
  logic [NBUF-1:0]     abort;
  logic [29*NBUF-1:0]  identifier;
  logic [NBUF-1:0]     extended;
  logic [NBUF-1:0]     remote;
  logic [4*NBUF-1:0]   datalen;
  logic                activ;
  logic                txok;
  logic                txerr;
  logic [38:0]         message;
  logic [3:0]          tmlen;
  logic [SW-1:0]       selbuf;
  logic                valid;
  logic [NBUF-1:0]     pending;
  logic [NBUF-1:0]     txdone;

  int n_checks = 0;
  int n_fail   = 0;

  encapsulation_mb #(.NBUF(NBUF), .SW(SW)) dut (
    .clock(clock), .reset(reset), .txreq(txreq), .abort(abort),
    .identifier(identifier), .extended(extended), .remote(remote),
    .datalen(datalen), .activ(activ), .txok(txok), .txerr(txerr),
    .message(message), .tmlen(tmlen), .selbuf(selbuf), .valid(valid),
    .pending(pending), .txdone(txdone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_buf(input int i, input logic [28:0] id, input logic ext,
                         input logic rtr, input logic [3:0] dlc);
    identifier[29*i +: 29] = id;
    extended[i]            = ext;
    remote[i]              = rtr;
    datalen[4*i +: 4]      = dlc;
  endtask

  initial begin
    reset = 1'b0; txreq = '0; abort = '0; identifier = '0; extended = '0;
    remote = '0; datalen = '0; activ = 1'b0; txok = 1'b0; txerr = 1'b0;

    // Reset holds everything at zero even with requests asserted
    txreq = 4'b1111;
    tick(); tick();
    check("rst_message", message, 0);
    check("rst_tmlen", tmlen, 0);
    check("rst_selbuf", selbuf, 0);
    check("rst_valid", valid, 0);
    check("rst_pending", pending, 0);
    check("rst_txdone", txdone, 0);
    txreq = '0;
    reset = 1'b1;
    tick();

    // Standard buf1 beats standard buf0 with higher base
    set_buf(0, 29'h1FFC0000, 1'b0, 1'b0, 4'd2);
    set_buf(1, 29'h048C0000, 1'b0, 1'b0, 4'd12);
    set_buf(2, 29'h01234567, 1'b1, 1'b0, 4'd3);
    txreq = 4'b0011; tick(); txreq = '0;
    check("a_pending", pending, 4'b0011);
    activ = 1'b1; tick();
    check("a_select_valid", valid, 0);
    tick();
    check("a_valid", valid, 1);
    check("a_selbuf", selbuf, 1);
    check("a_base", message[17:7], 11'h123);
    check("a_message", message, 39'h918C);
    check("a_tmlen", tmlen, 8);
    check("a_dlc", message[3:0], 4'd12);
    // abort of locked buf1 ignored, buf0 aborted; input change has no effect
    abort = 4'b0011;
    set_buf(1, 29'h1FFFFFFF, 1'b0, 1'b1, 4'd1);
    tick(); abort = '0;
    check("a_abort_pending", pending, 4'b0010);
    check("a_lock_message", message, 39'h918C);
    check("a_lock_tmlen", tmlen, 8);
    check("a_lock_valid", valid, 1);
    txok = 1'b1; tick(); txok = 1'b0;
    check("a_txdone", txdone, 4'b0010);
    check("a_txok_pending", pending, 0);
    check("a_txok_valid", valid, 0);
    tick();
    check("a_txdone_once", txdone, 0);
    check("a_hold_message", message, 39'h918C);
    check("a_hold_selbuf", selbuf, 1);
    // txreq wins over abort; no relock while activ stays high
    txreq = 4'b0001; abort = 4'b0001; tick(); txreq = '0; abort = '0;
    check("a_req_wins", pending, 4'b0001);
    txok = 1'b1; tick(); txok = 1'b0;
    check("a_idle_txok_pending", pending, 4'b0001);
    check("a_idle_txok_txdone", txdone, 0);
    check("a_no_rise_valid", valid, 0);
    abort = 4'b0001; tick(); abort = '0;
    check("a_idle_abort", pending, 0);
    activ = 1'b0; tick();

    // Extended buf2 (base 0x048) beats buf1 (base 0x7FF); txerr then txok
    txreq = 4'b0110; tick(); txreq = '0;
    activ = 1'b1; tick(); tick();
    check("b_selbuf", selbuf, 2);
    check("b_valid", valid, 1);
    check("b_message", message, {1'b0, 11'h048, 2'b11, 18'h34567, 1'b0, 2'b00, 4'h3});
    check("b_tmlen", tmlen, 3);
    txerr = 1'b1; tick(); txerr = 1'b0;
    check("b_err_valid", valid, 0);
    check("b_err_pending", pending, 4'b0110);
    check("b_err_txdone", txdone, 0);
    activ = 1'b0; tick();
    activ = 1'b1; tick(); tick();
    check("b_relock_selbuf", selbuf, 2);
    check("b_relock_valid", valid, 1);
    txok = 1'b1; txerr = 1'b1; tick(); txok = 1'b0; txerr = 1'b0;
    check("b_txdone", txdone, 4'b0100);
    check("b_pending", pending, 4'b0010);
    tick();
    check("b_txdone_once", txdone, 0);
    abort = 4'b0010; tick(); abort = '0;
    activ = 1'b0; tick();

    // Standard data vs extended, same base: standard wins
    set_buf(0, 29'h1FFC0000, 1'b0, 1'b0, 4'd2);
    set_buf(3, 29'h1FFC0000, 1'b1, 1'b0, 4'd15);
    txreq = 4'b1001; tick(); txreq = '0;
    activ = 1'b1; tick(); tick();
    check("c1_selbuf", selbuf, 0);
    check("c1_tmlen", tmlen, 2);
    txerr = 1'b1; tick(); txerr = 1'b0;
    activ = 1'b0; tick();
    // Standard RTR vs extended, same base: standard still wins on IDE
    remote[0] = 1'b1;
    activ = 1'b1; tick(); tick();
    check("c2_selbuf", selbuf, 0);
    check("c2_message", message, 39'h3FFC2);
    check("c2_tmlen", tmlen, 0);
    txerr = 1'b1; tick(); txerr = 1'b0;
    activ = 1'b0; tick();
    // Both extended, buf3 lower extended ID
    set_buf(0, 29'h1FFC0010, 1'b1, 1'b0, 4'd2);
    set_buf(3, 29'h1FFC0005, 1'b1, 1'b0, 4'd15);
    activ = 1'b1; tick(); tick();
    check("c3_selbuf", selbuf, 3);
    check("c3_tmlen", tmlen, 8);
    check("c3_message", message, {1'b0, 11'h7FF, 2'b11, 18'h00005, 1'b0, 2'b00, 4'hF});
    activ = 1'b0; tick();
    check("c3_drop_valid", valid, 0);
    check("c3_drop_pending", pending, 4'b1001);
    // Identical keys tie to lowest index
    set_buf(3, 29'h1FFC0010, 1'b1, 1'b0, 4'd15);
    activ = 1'b1; tick(); tick();
    check("c4_tie_selbuf", selbuf, 0);
    activ = 1'b0; tick();
    abort = 4'b1001; tick(); abort = '0;
    check("c_clear_pending", pending, 0);

    // activ rise with nothing pending stays idle
    activ = 1'b1; tick(); tick(); tick();
    check("d_empty_valid", valid, 0);
    txreq = 4'b0010; tick(); txreq = '0;
    activ = 1'b0; tick();
    activ = 1'b1; tick(); tick();
    check("d_lock_valid", valid, 1);
    check("d_lock_selbuf", selbuf, 1);
    // Reset in LOCK clears everything, overriding requests
    reset = 1'b0; txreq = 4'b1111; tick();
    check("d_rst_message", message, 0);
    check("d_rst_tmlen", tmlen, 0);
    check("d_rst_selbuf", selbuf, 0);
    check("d_rst_valid", valid, 0);
    check("d_rst_pending", pending, 0);
    check("d_rst_txdone", txdone, 0);
    reset = 1'b1; txreq = '0; activ = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
